// File: rtl/vector_reduction_unit_pkg.sv
// vector_reduction_unit_pkg: shared types, sizes and element helpers for the reduction unit
package vector_reduction_unit_pkg;
  localparam int NUM_LANES = 4;
  localparam int VL_WIDTH = 7;
  typedef enum logic [2:0] {VRED_SUM, VRED_AND, VRED_OR, VRED_XOR, VRED_MIN, VRED_MAX, VRED_UMN, VRED_UMX} vredop_t;
  typedef enum logic [1:0] {SEW8, SEW16, SEW32, SEW64} vsew_t;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} vred_state_t;
  function automatic logic [31:0] trunc(input logic [31:0] v, input vsew_t s);
    return s == SEW8 ? {24'd0, v[7:0]} : s == SEW16 ? {16'd0, v[15:0]} : v;
  endfunction
  function automatic logic [31:0] ext(input logic [31:0] v, input vsew_t s, input logic sx);
    return s == SEW8 ? {{24{sx & v[7]}}, v[7:0]} : s == SEW16 ? {{16{sx & v[15]}}, v[15:0]} : v;
  endfunction
  function automatic logic [31:0] identity(input vredop_t op, input vsew_t s);
    logic [31:0] msb;
    msb = s == SEW8 ? 32'h80 : s == SEW16 ? 32'h8000 : 32'h8000_0000;
    return op inside {VRED_AND, VRED_UMN} ? trunc(32'hFFFF_FFFF, s) :
           op == VRED_MAX ? msb : op == VRED_MIN ? msb - 32'd1 : 32'd0;
  endfunction
endpackage

// File: rtl/vector_reduction_unit_if.sv
// vector_reduction_unit_if: request, element-beat and result handshakes of the reduction unit
interface vector_reduction_unit_if;
  import vector_reduction_unit_pkg::*;
  logic start;
  vredop_t vredop;
  vsew_t vsew;
  logic [VL_WIDTH:0] vl;
  logic vwiden;
  logic vsigned;
  logic [31:0] scalar_in;
  logic elem_valid;
  logic elem_ready;
  logic [NUM_LANES*32-1:0] elem_data;
  logic [NUM_LANES-1:0] elem_mask;
  logic result_valid;
  logic result_ready;
  logic [31:0] result_data;
  logic result_wen;
  logic busy;
  logic illegal;
  modport master (
    output start, vredop, vsew, vl, vwiden, vsigned, scalar_in, elem_valid, elem_data, elem_mask, result_ready,
    input elem_ready, result_valid, result_data, result_wen, busy, illegal
  );
  modport slave (
    input start, vredop, vsew, vl, vwiden, vsigned, scalar_in, elem_valid, elem_data, elem_mask, result_ready,
    output elem_ready, result_valid, result_data, result_wen, busy, illegal
  );
endinterface

// File: rtl/vector_reduction_unit_lane_tree.sv
// vred_lane_tree: folds the accumulator with one beat of lanes, inactive lanes replaced by the op identity
module vred_lane_tree
  import vector_reduction_unit_pkg::*;
(
  input  vredop_t                 op_i,
  input  vsew_t                   sew_i,
  input  logic                    wid_i,
  input  logic                    sgn_i,
  input  logic [31:0]             acc_i,
  input  logic [NUM_LANES*32-1:0] data_i,
  input  logic [NUM_LANES-1:0]    act_i,
  output logic [31:0]             acc_o
);
  vsew_t rsew;
  logic mm, sx;
  logic [31:0] r, e;
  // signed ops compare sign-extended values; widening sums extend sources per vsigned and wrap at 2*SEW
  always_comb begin
    rsew = wid_i ? vsew_t'(sew_i + 2'd1) : sew_i;
    mm = op_i inside {VRED_MIN, VRED_MAX};
    sx = mm || (wid_i && sgn_i);
    r = ext(acc_i, rsew, mm);
    e = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      e = ext(act_i[i] ? data_i[32*i +: 32] : identity(op_i, sew_i), sew_i, sx);
      r = op_i == VRED_SUM ? r + e :
          op_i == VRED_AND ? r & e :
          op_i == VRED_OR  ? r | e :
          op_i == VRED_XOR ? r ^ e :
          op_i == VRED_MIN ? ($signed(e) < $signed(r) ? e : r) :
          op_i == VRED_MAX ? ($signed(e) > $signed(r) ? e : r) :
          op_i == VRED_UMN ? (e < r ? e : r) : (e > r ? e : r);
    end
    acc_o = trunc(r, rsew);
  end
endmodule

// File: rtl/vector_reduction_unit.sv
// vector_reduction_unit: multi-cycle integer vector reduction; define VRED_WIDEN_EN for widening sums
module vector_reduction_unit
  import vector_reduction_unit_pkg::*;
(
  input logic CLK,
  input logic RST,
  vector_reduction_unit_if.slave bus
);
  vred_state_t state_q, state_d;
  vredop_t op_q, op_d;
  vsew_t sew_q, sew_d, rsew_in;
  logic wid_q, wid_d, sgn_q, sgn_d, wen_q, wen_d, ill_q, ill_d, bad, win;
  logic [VL_WIDTH:0] vl_q, vl_d, idx_q, idx_d;
  logic [31:0] acc_q, acc_d, fold;
  logic [NUM_LANES-1:0] act;
`ifdef VRED_WIDEN_EN
  assign bad = bus.vsew > SEW32 || (bus.vwiden && (bus.vredop != VRED_SUM || bus.vsew == SEW32));
  assign win = bus.vwiden;
`else
  assign bad = bus.vsew > SEW32 || bus.vwiden;
  assign win = 1'b0;
`endif
  assign rsew_in = win ? vsew_t'(bus.vsew + 2'd1) : bus.vsew;
  vred_lane_tree u_tree (
    .op_i(op_q), .sew_i(sew_q), .wid_i(wid_q), .sgn_i(sgn_q),
    .acc_i(acc_q), .data_i(bus.elem_data), .act_i(act), .acc_o(fold)
  );
  // a lane is live when its mask bit is set and it lies below vl
  always_comb begin
    act = '0;
    for (int i = 0; i < NUM_LANES; i++) act[i] = bus.elem_mask[i] && (32'(idx_q) + i < 32'(vl_q));
  end
  // next state: latch config on a legal start, fold beats in ACCUM, release on result handshake
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    sew_d = sew_q;
    wid_d = wid_q;
    sgn_d = sgn_q;
    vl_d = vl_q;
    idx_d = idx_q;
    acc_d = acc_q;
    wen_d = wen_q;
    ill_d = 1'b0;
    if (state_q == IDLE && bus.start) begin
      ill_d = bad;
      if (!bad) begin
        op_d = bus.vredop;
        sew_d = bus.vsew;
        wid_d = win;
        sgn_d = bus.vsigned;
        vl_d = bus.vl;
        idx_d = '0;
        acc_d = trunc(bus.scalar_in, rsew_in);
        wen_d = bus.vl != '0;
        state_d = bus.vl == '0 ? DONE : ACCUM;
      end
    end
    if (state_q == ACCUM && bus.elem_valid) begin
      acc_d = fold;
      idx_d = idx_q + (VL_WIDTH+1)'(NUM_LANES);
      state_d = 32'(idx_q) + NUM_LANES >= 32'(vl_q) ? DONE : ACCUM;
    end
    if (state_q == DONE && bus.result_ready) state_d = IDLE;
  end
  // state, accumulator and latched configuration
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      op_q <= VRED_SUM;
      sew_q <= SEW8;
      wid_q <= 1'b0;
      sgn_q <= 1'b0;
      vl_q <= '0;
      idx_q <= '0;
      acc_q <= '0;
      wen_q <= 1'b0;
      ill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      sew_q <= sew_d;
      wid_q <= wid_d;
      sgn_q <= sgn_d;
      vl_q <= vl_d;
      idx_q <= idx_d;
      acc_q <= acc_d;
      wen_q <= wen_d;
      ill_q <= ill_d;
    end
  end
  assign bus.elem_ready = state_q == ACCUM;
  assign bus.result_valid = state_q == DONE;
  assign bus.result_data = acc_q;
  assign bus.result_wen = state_q == DONE && wen_q;
  assign bus.busy = state_q != IDLE;
  assign bus.illegal = ill_q;
endmodule
